// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encodings, default widths and the in-flight
// tracking entry used by the round-robin scheduler.
package fpu_pkg;

  localparam logic FPU_OP_ADD = 1'b0;
  localparam logic FPU_OP_MUL = 1'b1;

  localparam int FPU_DATA_WIDTH = 16;
  localparam int FPU_EXP_WIDTH  = 8;

  // Widest requester ID supported (NUM_REQ up to 16)
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } inflight_t;

endpackage

// File: rtl/fpu_rr_scheduler_if.sv
// Requester-side and FPU-side signal bundle of fpu_rr_scheduler.
// slave = the scheduler, master = the clients plus the FPU.
interface fpu_rr_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);

  // Handshake: requester i hands over its op in any cycle where
  // req_valid[i] && req_ready[i]; req_ready depends only on req_valid and the
  // internal pointer, never on anything downstream. Responses carry no ready:
  // rsp_valid[i] is a one-cycle pulse the requester must consume that cycle.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [2*DATA_WIDTH-1:0]       rsp_data;
  logic                          rsp_error;
  logic                          fpu_op;
  logic                          fpu_a_valid;
  logic                          fpu_b_valid;
  logic [DATA_WIDTH-1:0]         fpu_op_a;
  logic [DATA_WIDTH-1:0]         fpu_op_b;
  logic [2*DATA_WIDTH-1:0]       fpu_out;
  logic                          fpu_error;

  modport slave (
    input  req_valid, req_op, req_a, req_b, fpu_out, fpu_error,
    output req_ready, rsp_valid, rsp_data, rsp_error,
           fpu_op, fpu_a_valid, fpu_b_valid, fpu_op_a, fpu_op_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, fpu_out, fpu_error,
    input  req_ready, rsp_valid, rsp_data, rsp_error,
           fpu_op, fpu_a_valid, fpu_b_valid, fpu_op_a, fpu_op_b
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr_i upward with wrap and
// returns the one-hot grant, its index, and the pointer for the next cycle.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          adv_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic [IW-1:0] ptr_nxt_o
);

  always_comb begin
    logic found;
    int   idx;
    found       = 1'b0;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IW'(idx);
      end
    end
  end

  // The pointer moves just past the winner so it becomes lowest priority
  always_comb begin
    ptr_nxt_o = ptr_i;
    if (adv_i) begin
      ptr_nxt_o = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Round-robin scheduler sharing one FPU between NUM_REQ requesters.
// Defining FPU_RR_SCHEDULER_PERF_EN adds the issue_cnt / err_cnt counters.
module fpu_rr_scheduler
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH  = FPU_DATA_WIDTH,
  parameter int EXP_WIDTH   = FPU_EXP_WIDTH,
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 0
) (
  input logic               clk,
  input logic               rst,
  fpu_rr_scheduler_if.slave bus
`ifdef FPU_RR_SCHEDULER_PERF_EN
  ,
  output logic [31:0]       issue_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = FPU_LATENCY + 1;

  if (NUM_REQ < 1 || NUM_REQ > 16 || EXP_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_cfg
    $error("fpu_rr_scheduler: unsupported NUM_REQ/EXP_WIDTH/DATA_WIDTH");
  end

  logic [NUM_REQ-1:0]    req_live;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  // Requests are masked during reset so req_ready reads 0 while rst is low
  assign req_live = bus.req_valid & {NUM_REQ{rst}};
  assign accept   = |grant;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i       (req_live),
    .ptr_i       (ptr_q),
    .adv_i       (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .ptr_nxt_o   (ptr_d)
  );

  assign bus.req_ready = grant;
  assign sel_a = bus.req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b = bus.req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  vld_q;

  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    if (accept) begin
      op_d = bus.req_op[grant_idx];
      a_d  = sel_a;
      b_d  = sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      op_q  <= FPU_OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= accept;
    end
  end

  assign bus.fpu_op      = op_q;
  assign bus.fpu_op_a    = a_q;
  assign bus.fpu_op_b    = b_q;
  assign bus.fpu_a_valid = vld_q;
  assign bus.fpu_b_valid = vld_q;

  // Stage s is valid in T+1+s; the tail lines up with fpu_out of the op
  inflight_t line_q [STAGES];
  inflight_t line_d [STAGES];
  inflight_t tail;

  always_comb begin
    line_d[0] = '{vld: accept, id: MAX_ID_W'(grant_idx)};
    for (int s = 1; s < STAGES; s++) begin
      line_d[s] = line_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < STAGES; s++) begin
        line_q[s] <= '0;
      end
    end else begin
      line_q <= line_d;
    end
  end

  assign tail = line_q[STAGES-1];

  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q;
  logic                    rsp_error_q;

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = tail.vld && (tail.id == MAX_ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tail.vld) begin
        rsp_data_q  <= bus.fpu_out;
        rsp_error_q <= bus.fpu_error;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;

`ifdef FPU_RR_SCHEDULER_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Both counters saturate rather than wrap
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (accept && (issue_cnt_q != '1)) begin
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
    if (tail.vld && bus.fpu_error && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Bench for fpu_rr_scheduler: one instance with a combinational FPU stub and
// one with a 3-cycle FPU stub, checked through expected-response queues.
module tb_fpu_rr_scheduler;
  import fpu_pkg::*;

  localparam int EW = 69;  // {rsp_valid[4], data[32], error, cycle[32]}

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  logic mon_en;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

`ifdef FPU_RR_SCHEDULER_PERF_EN
  logic [31:0] issue_cnt0, issue_cnt1;
  logic [15:0] err_cnt0, err_cnt1;
`endif

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 200us");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and FPU stubs ----------------
  fpu_rr_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(16)) b0 ();
  fpu_rr_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(16)) b1 ();

  fpu_rr_scheduler #(.DATA_WIDTH(16), .EXP_WIDTH(8), .NUM_REQ(4), .FPU_LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
`ifdef FPU_RR_SCHEDULER_PERF_EN
    ,
    .issue_cnt (issue_cnt0),
    .err_cnt   (err_cnt0)
`endif
  );

  fpu_rr_scheduler #(.DATA_WIDTH(16), .EXP_WIDTH(8), .NUM_REQ(4), .FPU_LATENCY(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
`ifdef FPU_RR_SCHEDULER_PERF_EN
    ,
    .issue_cnt (issue_cnt1),
    .err_cnt   (err_cnt1)
`endif
  );

  assign b0.fpu_out   = {b0.fpu_op_a, b0.fpu_op_b};
  assign b0.fpu_error = (b0.fpu_op == FPU_OP_MUL);

  logic [15:0] s_a [3];
  logic [15:0] s_b [3];
  logic        s_e [3];

  always @(posedge clk) begin
    s_a[0] <= b1.fpu_op_a;
    s_b[0] <= b1.fpu_op_b;
    s_e[0] <= (b1.fpu_op == FPU_OP_MUL);
    for (int s = 1; s < 3; s++) begin
      s_a[s] <= s_a[s-1];
      s_b[s] <= s_b[s-1];
      s_e[s] <= s_e[s-1];
    end
  end

  assign b1.fpu_out   = {s_a[2], s_b[2]};
  assign b1.fpu_error = s_e[2];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [3:0] onehot(input int r);
    logic [3:0] v;
    v = 4'b0001;
    return v << r;
  endfunction

  function automatic logic [15:0] rot_a(input int r, input int k);
    return {4'(r), 4'h0, 8'(k)};
  endfunction

  function automatic logic [15:0] rot_b(input int r, input int k);
    return {8'(k), 4'hC, 4'(r)};
  endfunction

  // Called just after a posedge; presents one op on instance 0 for a cycle
  task automatic issue0(input int r, input logic op, input logic [15:0] a, input logic [15:0] b);
    b0.req_valid           = '0;
    b0.req_valid[r]        = 1'b1;
    b0.req_op[r]           = op;
    b0.req_a[r*16 +: 16]   = a;
    b0.req_b[r*16 +: 16]   = b;
    @(negedge clk);
    chk("issue0_ready", 64'(b0.req_ready), 64'(onehot(r)));
    exp_q0.push_back({onehot(r), a, b, op, 32'(cyc + 2)});
    @(posedge clk);
    #1;
    b0.req_valid = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon_en && (b0.rsp_valid !== 4'b0)) begin
      if (exp_q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp0_unexpected: got rsp_valid=%b, required no response", b0.rsp_valid);
      end else begin
        e = exp_q0.pop_front();
        chk("rsp0_valid", 64'(b0.rsp_valid), 64'(e[68:65]));
        chk("rsp0_data",  64'(b0.rsp_data),  64'(e[64:33]));
        chk("rsp0_error", 64'(b0.rsp_error), 64'(e[32]));
        chk("rsp0_cycle", 64'(cyc),          64'(e[31:0]));
      end
    end
    if (mon_en && (b1.rsp_valid !== 4'b0)) begin
      if (exp_q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp1_unexpected: got rsp_valid=%b, required no response", b1.rsp_valid);
      end else begin
        e = exp_q1.pop_front();
        chk("rsp1_valid", 64'(b1.rsp_valid), 64'(e[68:65]));
        chk("rsp1_data",  64'(b1.rsp_data),  64'(e[64:33]));
        chk("rsp1_error", 64'(b1.rsp_error), 64'(e[32]));
        chk("rsp1_cycle", 64'(cyc),          64'(e[31:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g;
    n_vec  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    cyc    = 0;
    rst    = 1'b1;
    b0.req_valid = '0; b0.req_op = '0; b0.req_a = '0; b0.req_b = '0;
    b1.req_valid = '0; b1.req_op = '0; b1.req_a = '0; b1.req_b = '0;
    #2 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready0",  64'(b0.req_ready),   64'(0));
    chk("rst_rsp0",    64'(b0.rsp_valid),   64'(0));
    chk("rst_aval0",   64'(b0.fpu_a_valid), 64'(0));
    chk("rst_opa1",    64'(b1.fpu_op_a),    64'(0));
    chk("rst_data1",   64'(b1.rsp_data),    64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // All requesters valid for 8 cycles: strict rotation on both instances
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 4; r++) begin
        b0.req_op[r] = 1'(r % 2);
        b1.req_op[r] = 1'(r % 2);
        b0.req_a[r*16 +: 16] = rot_a(r, k);
        b0.req_b[r*16 +: 16] = rot_b(r, k);
        b1.req_a[r*16 +: 16] = rot_a(r, k);
        b1.req_b[r*16 +: 16] = rot_b(r, k);
      end
      b0.req_valid = 4'b1111;
      b1.req_valid = 4'b1111;
      @(negedge clk);
      g = k % 4;
      chk("rot0_ready", 64'(b0.req_ready), 64'(onehot(g)));
      chk("rot1_ready", 64'(b1.req_ready), 64'(onehot(g)));
      exp_q0.push_back({onehot(g), rot_a(g, k), rot_b(g, k), 1'(g % 2), 32'(cyc + 2)});
      exp_q1.push_back({onehot(g), rot_a(g, k), rot_b(g, k), 1'(g % 2), 32'(cyc + 5)});
      @(posedge clk);
      #1;
    end
    b0.req_valid = '0;
    b1.req_valid = '0;
    repeat (8) @(posedge clk);
    #1;

    // Single ADD from requester 2, combinational FPU
    issue0(2, FPU_OP_ADD, 16'h3F80, 16'h4000);
    repeat (4) @(posedge clk);
    #1;

    // MULT from requester 1 on the 3-cycle FPU; fpu valids pulse only at T+1
    b1.req_valid          = 4'b0010;
    b1.req_op[1]          = FPU_OP_MUL;
    b1.req_a[16 +: 16]    = 16'h4040;
    b1.req_b[16 +: 16]    = 16'hC000;
    @(negedge clk);
    chk("t3_ready",  64'(b1.req_ready),   64'(4'b0010));
    chk("t3_aval_T", 64'(b1.fpu_a_valid), 64'(0));
    exp_q1.push_back({4'b0010, 32'h4040C000, 1'b1, 32'(cyc + 5)});
    @(posedge clk);
    #1;
    b1.req_valid = '0;
    @(negedge clk);
    chk("t3_aval_T1", 64'(b1.fpu_a_valid), 64'(1));
    chk("t3_bval_T1", 64'(b1.fpu_b_valid), 64'(1));
    chk("t3_op_T1",   64'(b1.fpu_op),      64'(1));
    chk("t3_opa_T1",  64'(b1.fpu_op_a),    64'(16'h4040));
    chk("t3_opb_T1",  64'(b1.fpu_op_b),    64'(16'hC000));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_aval_T2", 64'(b1.fpu_a_valid), 64'(0));
    repeat (8) @(posedge clk);
    #1;

    // Reset mid-flight: two accepted ops must never respond
    b1.req_valid       = 4'b1000;
    b1.req_op[3]       = FPU_OP_MUL;
    b1.req_a[48 +: 16] = 16'h7777;
    b1.req_b[48 +: 16] = 16'h8888;
    @(negedge clk);
    chk("t4_ready3", 64'(b1.req_ready), 64'(4'b1000));
    @(posedge clk);
    #1;
    b1.req_valid = 4'b0010;
    @(negedge clk);
    chk("t4_ready1", 64'(b1.req_ready), 64'(4'b0010));
    @(posedge clk);
    #1;
    b1.req_valid = '0;
    rst          = 1'b0;
    @(negedge clk);
    chk("t4_rsp_valid", 64'(b1.rsp_valid),   64'(0));
    chk("t4_rsp_data",  64'(b1.rsp_data),    64'(0));
    chk("t4_rsp_error", 64'(b1.rsp_error),   64'(0));
    chk("t4_fpu_op",    64'(b1.fpu_op),      64'(0));
    chk("t4_aval",      64'(b1.fpu_a_valid), 64'(0));
    chk("t4_bval",      64'(b1.fpu_b_valid), 64'(0));
    chk("t4_opa",       64'(b1.fpu_op_a),    64'(0));
    chk("t4_opb",       64'(b1.fpu_op_b),    64'(0));
    chk("t4_ready",     64'(b1.req_ready),   64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    b1.req_op          = '0;
    b1.req_a[0 +: 16]  = 16'h1111;
    b1.req_b[0 +: 16]  = 16'h2222;
    b1.req_valid       = 4'b1111;
    @(negedge clk);
    chk("t4_first_grant", 64'(b1.req_ready), 64'(4'b0001));
    exp_q1.push_back({4'b0001, 32'h11112222, 1'b0, 32'(cyc + 5)});
    @(posedge clk);
    #1;
    b1.req_valid = '0;
    repeat (8) @(posedge clk);
    #1;

`ifdef FPU_RR_SCHEDULER_PERF_EN
    // 10 accepts since reset, 4 of them MULT
    for (int k = 0; k < 10; k++) begin
      issue0(k % 4, (k < 4) ? FPU_OP_MUL : FPU_OP_ADD, 16'h5000 + 16'(k), 16'h6000 + 16'(k));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("perf_issue_cnt", 64'(issue_cnt0), 64'(10));
    chk("perf_err_cnt",   64'(err_cnt0),   64'(4));
    force dut0.issue_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut0.issue_cnt_q;
    issue0(1, FPU_OP_ADD, 16'h0001, 16'h0002);
    repeat (3) @(posedge clk);
    #1;
    chk("perf_issue_sat", 64'(issue_cnt0), 64'(32'hFFFF_FFFF));
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("q0_drained", 64'(exp_q0.size()), 64'(0));
    chk("q1_drained", 64'(exp_q1.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
